// File: rtl/bcd_to_bin_seq.sv
// Packed-BCD to binary converter, one digit per clock, most significant digit first (acc = acc*10 + d).
// Result and done appear N edges after an accepted ld; ld is ignored while busy.
module bcd_to_bin_seq #(
  parameter int N   = 8,
  parameter int WID = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [N*4-1:0]   i,
  output logic [WID-1:0]   o,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WID-1:0]   acc, acc_nxt, o_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [N*4-1:0]   sr, sr_nxt;
  logic             err_nxt;
  logic [3:0]       d;
  logic [WID+3:0]   mac;

  assign d   = sr[N*4-1 -: 4];
  // Extra headroom bits keep the multiply-add exact before truncation to WID.
  assign mac = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (WID+4)'(d);

  assign busy = (state == CONV);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sr    <= '0;
      o     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      o     <= o_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    o_nxt     = o;
    err_nxt   = err;
    case (state)
      IDLE, DONE: begin
        if (ld) begin
          sr_nxt    = i;
          acc_nxt   = '0;
          cnt_nxt   = CW'(N-1);
          err_nxt   = 1'b0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        acc_nxt = mac[WID-1:0];
        sr_nxt  = sr << 4;
        if (d > 4'd9) err_nxt = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          o_nxt     = mac[WID-1:0];
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: directed cases plus random operands against an arithmetic reference model.
module tb_bcd_to_bin_seq;
  localparam int N   = 8;
  localparam int WID = 27;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld  = 1'b0;
  logic [31:0]     i   = '0;
  logic [WID-1:0]  o;
  logic            busy, done, err;

  logic            ld2 = 1'b0;
  logic [3:0]      i2  = '0;
  logic [3:0]      o2;
  logic            busy2, done2, err2;

  int              checks = 0;
  int              errors = 0;
  logic [WID-1:0]  prev_o = '0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.N(N), .WID(WID)) dut (
    .clk(clk), .rst(rst), .ld(ld), .i(i), .o(o), .busy(busy), .done(done), .err(err)
  );

  bcd_to_bin_seq #(.N(1), .WID(4)) dut1 (
    .clk(clk), .rst(rst), .ld(ld2), .i(i2), .o(o2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits (invalid nibbles count at face value), modulo 2^WID.
  function automatic void model(input logic [31:0] v, output logic [WID-1:0] r, output logic e);
    longint a;
    int dd;
    a = 0;
    e = 1'b0;
    for (int g = N-1; g >= 0; g--) begin
      dd = int'((v >> (g*4)) & 32'hF);
      if (dd > 9) e = 1'b1;
      a = (a * 10 + longint'(dd)) % (longint'(1) << WID);
    end
    r = WID'(a);
  endfunction

  // Issue ld at the next edge and follow the conversion edge by edge.
  // junk_at (1..N-1) pulses a spurious ld with another operand on that CONV cycle.
  task automatic run(input logic [31:0] v, input logic [WID-1:0] exp_o, input logic exp_e,
                     input int junk_at);
    @(negedge clk); ld = 1'b1; i = v;
    @(negedge clk); ld = 1'b0; i = $urandom;
    chk("acc_busy", 64'(busy), 64'(1'b1));
    chk("acc_done", 64'(done), 64'(1'b0));
    chk("acc_err",  64'(err),  64'(1'b0));
    for (int c = 1; c < N; c++) begin
      if (c == junk_at) begin ld = 1'b1; i = 32'h99999999; end
      @(negedge clk); ld = 1'b0;
      chk("conv_busy",   64'(busy), 64'(1'b1));
      chk("conv_done",   64'(done), 64'(1'b0));
      chk("conv_o_hold", 64'(o),    64'(prev_o));
    end
    @(negedge clk);
    chk("res_o",    64'(o),    64'(exp_o));
    chk("res_err",  64'(err),  64'(exp_e));
    chk("res_done", 64'(done), 64'(1'b1));
    chk("res_busy", 64'(busy), 64'(1'b0));
    prev_o = exp_o;
  endtask

  initial begin
    logic [31:0]    v;
    logic [WID-1:0] r;
    logic           e;

    repeat (2) @(negedge clk);
    chk("rst_o",     64'(o),     64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_err",   64'(err),   64'(0));
    chk("rst_o_n1",  64'(o2),    64'(0));
    chk("rst_bd_n1", 64'({busy2, done2, err2}), 64'(0));
    rst = 1'b0;

    // Directed cases
    run(32'h99999999, 27'h5F5E0FF, 1'b0, 0);
    run(32'h12345678, 27'hBC614E,  1'b0, 0);
    run(32'h00000000, 27'h0,       1'b0, 0);
    run(32'h1234A678, 27'hBC74D6,  1'b1, 0);
    run(32'h00000001, 27'h1,       1'b0, 0);
    run(32'h00000042, 27'h2A,      1'b0, 3);

    // DONE holds its result while ld stays low
    repeat (3) begin
      @(negedge clk);
      chk("hold_done", 64'(done), 64'(1'b1));
      chk("hold_o",    64'(o),    64'(27'h2A));
    end

    // Reset in the middle of a conversion aborts it
    @(negedge clk); ld = 1'b1; i = 32'h87654321;
    @(negedge clk); ld = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1'b1));
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_o",    64'(o),    64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_err",  64'(err),  64'(0));
    prev_o = '0;
    @(negedge clk);
    chk("idle_done", 64'(done), 64'(0));
    run(32'h87654321, 27'h5397FB1, 1'b0, 0);

    // Random operands, half of them restricted to valid digits
    for (int t = 0; t < 30; t++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        for (int g = 0; g < N; g++) v[g*4 +: 4] = 4'($urandom_range(0, 9));
      end
      model(v, r, e);
      run(v, r, e, (t % 3 == 0) ? int'($urandom_range(1, N-1)) : 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rnd_hold_done", 64'(done), 64'(1'b1));
      end
    end

    // Single-digit instance
    @(negedge clk); ld2 = 1'b1; i2 = 4'h7;
    @(negedge clk); ld2 = 1'b0;
    chk("n1_busy", 64'(busy2), 64'(1'b1));
    @(negedge clk);
    chk("n1_o7",    64'(o2),    64'(4'h7));
    chk("n1_done7", 64'(done2), 64'(1'b1));
    chk("n1_err7",  64'(err2),  64'(1'b0));
    ld2 = 1'b1; i2 = 4'hF;
    @(negedge clk); ld2 = 1'b0;
    chk("n1_restart_done", 64'(done2), 64'(1'b0));
    @(negedge clk);
    chk("n1_oF",    64'(o2),    64'(4'hF));
    chk("n1_errF",  64'(err2),  64'(1'b1));
    chk("n1_doneF", 64'(done2), 64'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential packed-BCD to unsigned binary converter. It is the inverse of the binary-to-BCD table used alongside the BCD add/sub/mul datapath in the decimal FPU. It converts an N-digit BCD significand to binary, one digit per clock, using Horner's method (acc = acc*10 + digit, most-significant digit first). It uses a start/busy/done handshake so the decimal unit can hand results to binary logic such as exponent or shift-count arithmetic.

Parameters:
N, 8, number of BCD digits in the input.
WID, 27, binary output width. It must be at least ceil(log2(10^N)); 27 bits covers N=8. With a smaller WID the result is truncated modulo 2^WID and no flag is raised.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
ld  input  1  start request; sampled only when busy=0.
i  input  N*4  packed BCD operand; digit g is in i[g*4+3:g*4]; digit N-1 is most significant.
o  output  WID  binary result register.
busy  output  1  high while converting.
done  output  1  result valid; level signal, held until the next accepted ld or rst.
err  output  1  sticky flag: some input nibble was greater than 9; valid when done=1.

Behaviour:
- Reset (rst=1 at an edge) gives: state=IDLE, o=0, busy=0, done=0, err=0, internal acc=0, digit counter=0, shift register=0.
- rst takes priority over everything. Reset mid-conversion aborts it; done is not asserted and o=0.
- States: IDLE, CONV, DONE.
- IDLE/DONE with ld=1 at an edge:
  - capture i into the shift register; acc=0; cnt=N-1; err=0.
  - done=0, busy=1, state goes to CONV.
  - o keeps its previous value.
- IDLE/DONE with ld=0: hold all state.
- CONV, every edge:
  - d = top nibble of the shift register.
  - acc_next = acc*10 + d, computed as (acc<<3)+(acc<<1)+d and truncated to WID bits.
  - shift register shifts left 4 bits, zero-filled.
  - If d > 9, set err=1. An invalid nibble still contributes its raw value 10..15 to the sum.
  - If cnt != 0: cnt decrements and the state stays CONV.
  - If cnt == 0: o=acc_next, done=1, busy=0, state goes to DONE. err is final in the same edge.
- ld while busy=1 is ignored entirely; i is not resampled and the conversion continues.
- Latency: with ld accepted at edge k, done=1 and o are valid after edge k+N. Throughput is one conversion per N+1 cycles.
- Back-to-back operation: ld=1 at the edge that would otherwise stay in DONE is accepted. done drops to 0 after that edge.
- busy and done are never both 1. In IDLE after reset both are 0.
- N=1 is legal: conversion completes one edge after ld.
- Input i is only required to be stable at the ld acceptance edge.

Test Plan:
1. Reset, then ld with i=32'h99999999 → busy=1 for 8 cycles; done=1 after the 8th CONV edge; o=27'h5F5E0FF; err=0.
2. ld with i=32'h12345678 → o=27'hBC614E, done after 8 edges. Then ld with i=32'h00000000 directly from DONE → done drops to 0, then rises 8 edges later with o=0; o reads 27'hBC614E until that edge.
3. ld with i=32'h1234A678 → err=1 and o=27'hBC74D6 at done. Then ld with 32'h00000001 → err clears at acceptance; result o=1, err=0.
4. ld with 32'h00000042, then pulse ld with 32'h99999999 on CONV cycle 3 → second request ignored; o=27'h2A at the original done time; busy never re-extends.
5. Assert rst on CONV cycle 4 of a conversion of 32'h87654321 → next cycle o=0, busy=0, done=0, err=0, state IDLE. A following ld of 32'h87654321 gives o=27'h5397FB1.
6. N=1, WID=4 instance: ld with i=4'h7 → done one edge later with o=4'h7. ld with i=4'hF → o=4'hF and err=1.
